nas2_vrow_seq: RTL and testbench

Vertical row sequencer for the NASCOM 2 video path: the counter that drives the 32-entry vertical timing PROM's address inputs and acts on the two strobes the PROM returns. Bit d0 of the PROM is /ld. When /ld is low, this block reloads its row counter to 11; otherwise the counter increments. Bit d1 is /vblank, which the block registers and forwards to the video output stage. The block also counts scan lines within each character row and provides the VDU row number, frame-start and vsync outputs to the video RAM addressing and sync logic.

---
 rtl/nas2_vrow_seq.sv | 117 +++++++++++
 tb/tb_nas2_vrow_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/nas2_vrow_seq.sv
// nas2_vrow_seq
// Vertical row sequencer for the NASCOM 2 video path. It drives the vertical
// timing PROM address (a4..a0), acts on the PROM /ld strobe to reload the row
// counter, registers the PROM /vblank strobe and produces scan line, VDU row,
// frame-start and vsync timing for the video RAM addressing and sync logic.
module nas2_vrow_seq #(
   parameter int ROW_LINES   = 16,
   parameter int VSYNC_LINES = 4,
   parameter int LOAD_VALUE  = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line_tick,
   input  logic       prom_d1,
   input  logic       prom_d0,
   output logic       prom_ce_n,
   output logic       a4,
   output logic       a3,
   output logic       a2,
   output logic       a1,
   output logic       a0,
   output logic [3:0] scan,
   output logic [3:0] vdu_row,
   output logic       vblank_n,
   output logic       frame_start,
   output logic       vsync_n
);

   localparam logic [3:0] SCAN_LAST  = 4'(ROW_LINES - 1);
   localparam logic [3:0] VSYNC_LAST = 4'(VSYNC_LINES - 1);
   localparam logic [4:0] ROW_LOAD   = 5'(LOAD_VALUE);

   logic [4:0] row;
   logic [3:0] vsync_cnt;
   logic       active;
   logic       line_evt;
   logic       row_adv;
   logic       wrap;

   // The PROM outputs are only trusted once the PROM is enabled, so every
   // event that looks at prom_d0/prom_d1 is qualified by the enable. This
   // keeps X/Z on the PROM pins during reset from reaching any state.
   assign active   = ~prom_ce_n;
   assign line_evt = active & line_tick;
   assign row_adv  = line_evt & (scan == SCAN_LAST);
   assign wrap     = row_adv & prom_d0 & (row == 5'd31);

   assign a4      = row[4];
   assign a3      = row[3];
   assign a2      = row[2];
   assign a1      = row[1];
   assign a0      = row[0];
   assign vdu_row = row[3:0];

   // PROM enable: held off during reset, enabled from the first released edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prom_ce_n <= 1'b1;
      end else begin
         prom_ce_n <= 1'b0;
      end
   end

   // Scan line counter and row counter; a scan wrap is the only moment the
   // row may change, and a low /ld at that moment reloads instead of counting.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan <= 4'd0;
         row  <= 5'd0;
      end else if (line_evt) begin
         if (scan == SCAN_LAST) begin
            scan <= 4'd0;
            if (!prom_d0) begin
               row <= ROW_LOAD;
            end else begin
               row <= row + 5'd1;
            end
         end else begin
            scan <= scan + 4'd1;
         end
      end
   end

   // Blanking strobe: one register stage after the combinational PROM output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vblank_n <= 1'b0;
      end else if (active) begin
         vblank_n <= prom_d1;
      end else begin
         vblank_n <= 1'b0;
      end
   end

   // Frame start on the 31->0 wrap, and vsync held low for VSYNC_LINES line
   // ticks after it; a new frame start always restarts the vsync count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_start <= 1'b0;
         vsync_n     <= 1'b1;
         vsync_cnt   <= 4'd0;
      end else begin
         frame_start <= wrap;
         if (wrap) begin
            vsync_n   <= 1'b0;
            vsync_cnt <= 4'd0;
         end else if (line_evt && !vsync_n) begin
            if (vsync_cnt == VSYNC_LAST) begin
               vsync_n <= 1'b1;
            end else begin
               vsync_cnt <= vsync_cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nas2_vrow_seq.sv
// tb_nas2_vrow_seq
// Directed bench for the vertical row sequencer with ROW_LINES=4 and
// VSYNC_LINES=3, driven by a behavioural model of the standard vertical PROM.
module tb_nas2_vrow_seq;

   localparam int ROW_LINES   = 4;
   localparam int VSYNC_LINES = 3;
   localparam int LOAD_VALUE  = 11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       line_tick;
   logic       prom_d1;
   logic       prom_d0;
   logic       prom_ce_n;
   logic       a4, a3, a2, a1, a0;
   logic [3:0] scan;
   logic [3:0] vdu_row;
   logic       vblank_n;
   logic       frame_start;
   logic       vsync_n;

   logic [4:0] addr;
   logic       ovrEn;
   logic       ovrD0;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   nas2_vrow_seq #(
      .ROW_LINES  (ROW_LINES),
      .VSYNC_LINES(VSYNC_LINES),
      .LOAD_VALUE (LOAD_VALUE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .line_tick  (line_tick),
      .prom_d1    (prom_d1),
      .prom_d0    (prom_d0),
      .prom_ce_n  (prom_ce_n),
      .a4         (a4),
      .a3         (a3),
      .a2         (a2),
      .a1         (a1),
      .a0         (a0),
      .scan       (scan),
      .vdu_row    (vdu_row),
      .vblank_n   (vblank_n),
      .frame_start(frame_start),
      .vsync_n    (vsync_n)
   );

   assign addr = {a4, a3, a2, a1, a0};

   always #5 clk = ~clk;

   // Standard vertical PROM: /ld low only at address 1, /vblank high for
   // addresses 15..30, outputs floating while the PROM is disabled.
   always_comb begin
      prom_d0 = 1'b1;
      prom_d1 = 1'b0;
      if (prom_ce_n === 1'b1) begin
         prom_d0 = 1'bx;
         prom_d1 = 1'bx;
      end else begin
         prom_d0 = ovrEn ? ovrD0 : (addr != 5'd1);
         prom_d1 = (addr >= 5'd15) && (addr <= 5'd30);
      end
   end

   // Drive one clock with the given reset and line_tick, settle past the edge.
   task automatic applyStimulus(input logic rst, input logic lt);
      rst_n     = rst;
      line_tick = lt;
      @(posedge clk);
      #1;
      line_tick = 1'b0;
   endtask

   task automatic tickN(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, 1'b1);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Safety net in case the run ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence covering reset, a full frame, vsync, back-to-back
   // ticks, mid-frame reset, reload gating and the load-beats-wrap case.
   initial begin
      int          idx;
      int          fsSeen;
      logic [4:0]  expA;

      rst_n     = 1'b0;
      line_tick = 1'b0;
      ovrEn     = 1'b0;
      ovrD0     = 1'b1;

      $display("[TB] reset phase");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'(i % 2 == 0));
         checkOutput("reset_hold", {addr, scan, vblank_n, vsync_n, frame_start, prom_ce_n},
                     {5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      end
      applyStimulus(1'b1, 1'b0);
      checkOutput("release", {addr, scan, vblank_n, vsync_n, frame_start, prom_ce_n},
                  {5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0});

      $display("[TB] full frame");
      fsSeen = 0;
      for (int k = 1; k <= 92; k++) begin
         applyStimulus(1'b1, 1'b1);
         idx  = k / ROW_LINES;
         expA = (idx == 0) ? 5'd0 : (idx == 1) ? 5'd1 : (idx <= 22) ? 5'(idx + 9) : 5'd0;
         checkOutput("frame_addr_scan", {addr, scan}, {expA, 4'(k % ROW_LINES)});
         checkOutput("frame_fs", frame_start, (k == 92));
         checkOutput("frame_vsync", vsync_n, (k != 92));
         if (frame_start === 1'b1) fsSeen++;
         if (k == 24) checkOutput("vblank_latency", vblank_n, 1'b0);
         if (k < 92) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("frame_vblank", vblank_n, (expA >= 5'd15) && (expA <= 5'd30));
            checkOutput("frame_fs_idle", frame_start, 1'b0);
         end
      end
      checkOutput("frame_fs_count", fsSeen, 1);

      $display("[TB] vsync after wrap");
      applyStimulus(1'b1, 1'b0);
      checkOutput("fs_one_clk", {frame_start, vsync_n, vblank_n}, {1'b0, 1'b0, 1'b0});
      tickN(1);
      checkOutput("vsync_line1", {addr, scan, vsync_n}, {5'd0, 4'd1, 1'b0});
      tickN(1);
      checkOutput("vsync_line2", {addr, scan, vsync_n}, {5'd0, 4'd2, 1'b0});
      tickN(1);
      checkOutput("vsync_line3", {addr, scan, vsync_n}, {5'd0, 4'd3, 1'b1});
      tickN(1);
      checkOutput("row1", {addr, scan}, {5'd1, 4'd0});

      $display("[TB] back-to-back ticks");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1);
         checkOutput("b2b_scan", scan, 4'((i + 1) % 4));
         if (i == 3) checkOutput("b2b_row_a", addr, 5'd11);
         if (i == 7) checkOutput("b2b_row_b", addr, 5'd12);
      end

      $display("[TB] mid-frame reset");
      tickN(34);
      checkOutput("pre_reset_pos", {addr, scan}, {5'd20, 4'd2});
      checkOutput("vdu_row", vdu_row, 4'd4);
      applyStimulus(1'b0, 1'b1);
      checkOutput("midframe_reset", {addr, scan, vblank_n, vsync_n, frame_start, prom_ce_n},
                  {5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      applyStimulus(1'b1, 1'b0);
      checkOutput("midframe_release", {addr, scan, prom_ce_n}, {5'd0, 4'd0, 1'b0});

      $display("[TB] reload gating");
      ovrEn = 1'b1;
      ovrD0 = 1'b1;
      tickN(21);
      checkOutput("reach_row5", {addr, scan}, {5'd5, 4'd1});
      ovrD0 = 1'b0;
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("ld_idle_ignored", {addr, scan}, {5'd5, 4'd1});
      tickN(1);
      checkOutput("ld_midrow_a", {addr, scan}, {5'd5, 4'd2});
      tickN(1);
      checkOutput("ld_midrow_b", {addr, scan}, {5'd5, 4'd3});
      tickN(1);
      checkOutput("ld_on_advance", {addr, scan}, {5'd11, 4'd0});
      ovrEn = 1'b0;

      $display("[TB] load at row 31");
      tickN(83);
      checkOutput("reach_row31", {addr, scan}, {5'd31, 4'd3});
      ovrEn = 1'b1;
      ovrD0 = 1'b0;
      tickN(1);
      checkOutput("load_beats_wrap", {addr, scan, frame_start, vsync_n},
                  {5'd11, 4'd0, 1'b0, 1'b1});
      ovrEn = 1'b0;

      $display("[TB] reset during vsync");
      tickN(84);
      checkOutput("wrap_again", {addr, scan, frame_start, vsync_n},
                  {5'd0, 4'd0, 1'b1, 1'b0});
      tickN(1);
      checkOutput("vsync_low", {scan, vsync_n}, {4'd1, 1'b0});
      applyStimulus(1'b0, 1'b0);
      checkOutput("vsync_reset", {addr, scan, vblank_n, vsync_n, frame_start, prom_ce_n},
                  {5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1});
      applyStimulus(1'b1, 1'b0);
      tickN(4);
      checkOutput("restart", {addr, scan, vsync_n, frame_start}, {5'd1, 4'd0, 1'b1, 1'b0});

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
